// File: rtl/wash_payment_frontend.sv
// Customer-side payment and start unit for the car wash.
// Collects coin credit, checks it against the single/double wash price, pulses
// coin_in to the wash controller, returns change and holds double_wash until the
// controller reports completion. Handles cancel, idle auto-refund and a missing
// acknowledge from the wash controller (sticky fault).
module wash_payment_frontend #(
  parameter int CREDIT_W     = 5,
  parameter int PRICE_SINGLE = 4,
  parameter int PRICE_DOUBLE = 6,
  parameter int IDLE_TO      = 1000,
  parameter int ACK_TO       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_value_i,
  input  logic                start_btn_i,
  input  logic                sel_double_i,
  input  logic                cancel_btn_i,
  input  logic                wash_done_i,
  output logic                coin_in_o,
  output logic                double_wash_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                coin_reject_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] change_amount_o,
  output logic                busy_o,
  output logic                cycle_done_o,
  output logic                fault_o
);

  // Counters only need to reach TO-1; keep at least one bit for TO == 1.
  localparam int IDLE_W = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  localparam int ACK_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  // One extra bit so credit + coin can be tested for overflow.
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0] PRICE_S_W  = (CREDIT_W+1)'(PRICE_SINGLE);
  localparam logic [CREDIT_W:0] PRICE_D_W  = (CREDIT_W+1)'(PRICE_DOUBLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_WAIT_ACK,
    S_RUNNING
  } state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_amount_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic [ACK_W-1:0]    ack_cnt_q;
  logic                coin_in_q;
  logic                double_wash_q;
  logic                coin_reject_q;
  logic                change_valid_q;
  logic                busy_q;
  logic                cycle_done_q;
  logic                fault_q;

  logic [CREDIT_W:0]   coin_units_w;
  logic [CREDIT_W:0]   credit_sum_w;
  logic [CREDIT_W:0]   price_w;
  logic                in_payment_w;
  logic                coin_acc_w;
  logic                start_ok_w;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] start_change_w;

  // Credit units of a coin code; the foreign-coin code is worth nothing.
  function automatic logic [CREDIT_W:0] coin_units(input logic [1:0] code);
    case (code)
      2'b00:   coin_units = (CREDIT_W+1)'(1);
      2'b01:   coin_units = (CREDIT_W+1)'(2);
      2'b10:   coin_units = (CREDIT_W+1)'(5);
      default: coin_units = '0;
    endcase
  endfunction

  // Coin acceptance, price selection and the change owed on a valid start.
  always_comb begin
    coin_units_w   = coin_units(coin_value_i);
    credit_sum_w   = {1'b0, credit_q} + coin_units_w;
    in_payment_w   = (state_q == S_IDLE) || (state_q == S_COLLECT);
    coin_acc_w     = coin_valid_i && (coin_value_i != 2'b11) &&
                     (credit_sum_w <= CREDIT_MAX) && in_payment_w;
    credit_d       = coin_acc_w ? credit_sum_w[CREDIT_W-1:0] : credit_q;
    price_w        = sel_double_i ? PRICE_D_W : PRICE_S_W;
    // The price check uses registered credit; a same-cycle coin only adds change.
    start_ok_w     = ({1'b0, credit_q} >= price_w);
    start_change_w = credit_d - price_w[CREDIT_W-1:0];
  end

  // Payment/wash sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      change_amount_q <= '0;
      idle_cnt_q      <= '0;
      ack_cnt_q       <= '0;
      coin_in_q       <= 1'b0;
      double_wash_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      cycle_done_q    <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      coin_in_q      <= 1'b0;
      change_valid_q <= 1'b0;
      cycle_done_q   <= 1'b0;
      // Any coin not credited this cycle (foreign, overflow or busy) is returned.
      coin_reject_q  <= coin_valid_i && !coin_acc_w;

      case (state_q)
        S_IDLE: begin
          if (coin_acc_w) begin
            credit_q   <= credit_d;
            idle_cnt_q <= '0;
            state_q    <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (cancel_btn_i) begin
            change_amount_q <= credit_d;
            change_valid_q  <= 1'b1;
            credit_q        <= '0;
            fault_q         <= 1'b0;
            state_q         <= S_IDLE;
          end else if (start_btn_i && start_ok_w) begin
            change_amount_q <= start_change_w;
            change_valid_q  <= 1'b1;
            credit_q        <= '0;
            double_wash_q   <= sel_double_i;
            coin_in_q       <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= S_START;
          end else if (coin_valid_i || start_btn_i) begin
            credit_q   <= credit_d;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_W'(IDLE_TO - 1)) begin
            // Customer walked away: hand back whatever was inserted.
            change_amount_q <= credit_q;
            change_valid_q  <= 1'b1;
            credit_q        <= '0;
            state_q         <= S_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end

        S_START: begin
          ack_cnt_q <= '0;
          state_q   <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (!wash_done_i) begin
            state_q <= S_RUNNING;
          end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
            // Controller never left idle; the payment is not refunded.
            fault_q       <= 1'b1;
            double_wash_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end

        S_RUNNING: begin
          if (wash_done_i) begin
            cycle_done_q  <= 1'b1;
            double_wash_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_in_o       = coin_in_q;
  assign double_wash_o   = double_wash_q;
  assign credit_o        = credit_q;
  assign coin_reject_o   = coin_reject_q;
  assign change_valid_o  = change_valid_q;
  assign change_amount_o = change_amount_q;
  assign busy_o          = busy_q;
  assign cycle_done_o    = cycle_done_q;
  assign fault_o         = fault_q;

endmodule

// File: tb/tb_wash_payment_frontend.sv
// Bench for wash_payment_frontend: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the payment rules.
module tb_wash_payment_frontend;

  localparam int CW   = 5;
  localparam int PS   = 4;
  localparam int PD   = 6;
  localparam int ITO  = 50;
  localparam int ATO  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_value = 2'b00;
  logic          start_btn = 1'b0;
  logic          sel_double = 1'b0;
  logic          cancel_btn = 1'b0;
  logic          wash_done = 1'b1;
  logic          coin_in_o, double_wash_o, coin_reject_o, change_valid_o;
  logic          busy_o, cycle_done_o, fault_o;
  logic [CW-1:0] credit_o, change_amount_o;

  bit wd = 1'b1;
  int checks = 0;
  int errors = 0;

  // Model: customer session and wash progress.
  int m_credit;
  bit m_collecting;
  int m_stage;   // 0 no wash, 1 start pulse, 2 awaiting ack, 3 washing
  int m_quiet;
  int m_wait;
  bit e_coin_in, e_double, e_reject, e_cv, e_busy, e_cd, e_fault;
  int e_credit, e_change;

  wash_payment_frontend #(
    .CREDIT_W(CW), .PRICE_SINGLE(PS), .PRICE_DOUBLE(PD), .IDLE_TO(ITO), .ACK_TO(ATO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid_i(coin_valid), .coin_value_i(coin_value),
    .start_btn_i(start_btn), .sel_double_i(sel_double), .cancel_btn_i(cancel_btn),
    .wash_done_i(wash_done),
    .coin_in_o(coin_in_o), .double_wash_o(double_wash_o), .credit_o(credit_o),
    .coin_reject_o(coin_reject_o), .change_valid_o(change_valid_o),
    .change_amount_o(change_amount_o), .busy_o(busy_o),
    .cycle_done_o(cycle_done_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_collecting = 0; m_stage = 0; m_quiet = 0; m_wait = 0;
    e_coin_in = 0; e_double = 0; e_reject = 0; e_cv = 0; e_busy = 0;
    e_cd = 0; e_fault = 0; e_credit = 0; e_change = 0;
  endtask

  task automatic model_step(input bit cv, input logic [1:0] val, input bit st,
                            input bit sd, input bit cn, input bit wdone);
    int units, price, total;
    bit acc;
    e_coin_in = 0; e_cv = 0; e_cd = 0;
    units = (val == 2'd0) ? 1 : (val == 2'd1) ? 2 : (val == 2'd2) ? 5 : 0;
    acc   = cv && (val != 2'd3) && (m_credit + units <= CMAX) && (m_stage == 0);
    e_reject = cv && !acc;
    price = sd ? PD : PS;
    total = m_credit + (acc ? units : 0);
    if (m_stage == 0 && !m_collecting) begin
      if (acc) begin
        m_credit = total; m_collecting = 1; m_quiet = 0;
      end
    end else if (m_stage == 0) begin
      if (cn) begin
        e_change = total; e_cv = 1; m_credit = 0; m_collecting = 0; e_fault = 0;
      end else if (st && m_credit >= price) begin
        e_change = total - price; e_cv = 1; m_credit = 0; m_collecting = 0;
        e_double = sd; e_coin_in = 1; m_stage = 1;
      end else if (cv || st) begin
        m_credit = total; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == ITO) begin
          e_change = m_credit; e_cv = 1; m_credit = 0; m_collecting = 0;
        end
      end
    end else if (m_stage == 1) begin
      m_stage = 2; m_wait = 0;
    end else if (m_stage == 2) begin
      if (!wdone) m_stage = 3;
      else begin
        m_wait++;
        if (m_wait == ATO) begin e_fault = 1; e_double = 0; m_stage = 0; end
      end
    end else begin
      if (wdone) begin e_cd = 1; e_double = 0; m_stage = 0; end
    end
    e_busy = (m_stage != 0);
    e_credit = m_credit;
  endtask

  task automatic check_all();
    chk("coin_in", 32'(coin_in_o), 32'(e_coin_in));
    chk("double_wash", 32'(double_wash_o), 32'(e_double));
    chk("credit", 32'(credit_o), 32'(e_credit));
    chk("coin_reject", 32'(coin_reject_o), 32'(e_reject));
    chk("change_valid", 32'(change_valid_o), 32'(e_cv));
    chk("change_amount", 32'(change_amount_o), 32'(e_change));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("cycle_done", 32'(cycle_done_o), 32'(e_cd));
    chk("fault", 32'(fault_o), 32'(e_fault));
  endtask

  task automatic cycle(input bit cv, input logic [1:0] val, input bit st,
                       input bit sd, input bit cn);
    coin_valid = cv; coin_value = val; start_btn = st; sel_double = sd;
    cancel_btn = cn; wash_done = wd;
    model_step(cv, val, st, sd, cn, wd);
    @(posedge clk);
    @(negedge clk);
    coin_valid = 0; start_btn = 0; cancel_btn = 0;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] val);
    cycle(1'b1, val, 1'b0, 1'b0, 1'b0);
  endtask

  // Wash controller acknowledges, washes for n cycles, then reports done.
  task automatic run_wash(input int n);
    wd = 0;
    idle();
    idle();
    repeat (n) idle();
    wd = 1;
    idle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle();

    // Single wash: 2 + 2, start single.
    coin(2'b01); coin(2'b01);
    chk("single_credit", 32'(credit_o), 32'd4);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("single_coin_in", 32'(coin_in_o), 32'd1);
    chk("single_change", 32'(change_amount_o), 32'd0);
    run_wash(3);
    chk("single_done", 32'(cycle_done_o), 32'd1);

    // Double wash with change: 5 + 2, start double -> change 1.
    coin(2'b10); coin(2'b01);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("double_change", 32'(change_amount_o), 32'd1);
    chk("double_flag", 32'(double_wash_o), 32'd1);
    wd = 0; idle(); idle(); idle();
    chk("double_held", 32'(double_wash_o), 32'd1);
    coin(2'b00);
    chk("running_reject", 32'(coin_reject_o), 32'd1);
    wd = 1; idle();
    chk("double_dropped", 32'(double_wash_o), 32'd0);

    // Insufficient credit then cancel.
    coin(2'b10);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("insuff_no_start", 32'(coin_in_o), 32'd0);
    chk("insuff_credit", 32'(credit_o), 32'd5);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("cancel_refund", 32'(change_amount_o), 32'd5);

    // Credit ceiling and foreign coin.
    repeat (6) coin(2'b10);
    coin(2'b01);
    chk("overflow_reject", 32'(coin_reject_o), 32'd1);
    chk("overflow_credit", 32'(credit_o), 32'd30);
    coin(2'b11);
    chk("foreign_reject", 32'(coin_reject_o), 32'd1);
    coin(2'b00);
    chk("max_credit", 32'(credit_o), 32'd31);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Idle auto-refund.
    coin(2'b00);
    repeat (ITO - 1) idle();
    chk("timeout_early", 32'(change_valid_o), 32'd0);
    idle();
    chk("timeout_refund", 32'(change_valid_o), 32'd1);
    chk("timeout_amount", 32'(change_amount_o), 32'd1);

    // Missing acknowledge -> fault; fault does not block, cancel clears it.
    coin(2'b01); coin(2'b01);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (ATO) idle();
    chk("fault_early", 32'(fault_o), 32'd0);
    idle();
    chk("fault_set", 32'(fault_o), 32'd1);
    coin(2'b01); coin(2'b01);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("fault_no_block", 32'(coin_in_o), 32'd1);
    run_wash(2);
    coin(2'b00);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("fault_cleared", 32'(fault_o), 32'd0);

    // Same-cycle coin with start, then cancel beating start.
    coin(2'b01); coin(2'b01);
    cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("coin_start_change", 32'(change_amount_o), 32'd2);
    run_wash(1);
    coin(2'b01); coin(2'b01);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("cancel_over_start", 32'(coin_in_o), 32'd0);
    chk("cancel_over_start_amt", 32'(change_amount_o), 32'd4);

    // Reset in the middle of a double wash.
    coin(2'b10); coin(2'b01);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    wd = 0; idle(); idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_double", 32'(double_wash_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wd = 1;
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wd = ($urandom_range(0, 99) < 65);
      cycle($urandom_range(0, 99) < 30, 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 12, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
